// File: rtl/uart_pkg.sv
// uart_pkg: FSM states, frame line levels and default divisor width shared by the UART TX and RX paths.
package uart_pkg;
    localparam int DIV_W_DEF = 16;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL = 1'b1;
    localparam logic IDLE_LVL = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/uart_tx_engine_if.sv
// uart_tx_engine_if: valid/ready byte handshake with per-transfer bit divisor.
interface uart_tx_engine_if import uart_pkg::*; #(parameter int DATA_BITS = 8, parameter int DIV_W = DIV_W_DEF);
    logic tx_valid;
    logic tx_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic [DIV_W-1:0] clk_div;
    modport master(output tx_valid, tx_data, clk_div, input tx_ready);
    modport slave(input tx_valid, tx_data, clk_div, output tx_ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable down-counter; tick is high while the count sits at zero.
module uart_baud_cnt #(parameter int W = 16) (
    input logic clk,
    input logic reset_n,
    input logic load,
    input logic [W-1:0] load_val,
    output logic tick
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - W'(1);
    end
    assign tick = cnt == '0;
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 8N1 LSB-first serializer with runtime divisor; UART_TX_PARITY_EN adds an even parity bit.
module uart_tx_engine import uart_pkg::*; #(
    parameter int DIV_W = DIV_W_DEF,
    parameter int DATA_BITS = 8
) (
    input logic clk,
    input logic reset_n,
    uart_tx_engine_if.slave bus,
    output logic tx,
    output logic tx_busy
);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);
    state_t state;
    logic armed, tick, hs, load;
    logic [DATA_BITS-1:0] shift;
    logic [DIV_W-1:0] div, div_in;
    logic [IW-1:0] idx;
`ifdef UART_TX_PARITY_EN
    logic par;
`endif
    assign div_in = bus.clk_div == '0 ? DIV_W'(1) : bus.clk_div;
    // armed holds ready low for the first edge after reset release
    assign bus.tx_ready = armed && (state == IDLE || (state == STOP && tick));
    assign hs = bus.tx_valid && bus.tx_ready;
    assign load = hs || (tick && state != IDLE && state != STOP);
    uart_baud_cnt #(.W(DIV_W)) u_baud (
        .clk(clk),
        .reset_n(reset_n),
        .load(load),
        .load_val(hs ? div_in - DIV_W'(1) : div - DIV_W'(1)),
        .tick(tick)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            armed <= 1'b0;
            tx <= IDLE_LVL;
            tx_busy <= 1'b0;
            shift <= '0;
            div <= '0;
            idx <= '0;
`ifdef UART_TX_PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            armed <= 1'b1;
            if (hs) begin
                state <= START;
                tx <= START_LVL;
                tx_busy <= 1'b1;
                shift <= bus.tx_data;
                div <= div_in;
                idx <= '0;
`ifdef UART_TX_PARITY_EN
                par <= ^bus.tx_data;
`endif
            end else if (tick) begin
                case (state)
                    START: begin
                        state <= DATA;
                        tx <= shift[0];
                    end
                    DATA: begin
                        if (idx == LAST) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx <= par;
`else
                            state <= STOP;
                            tx <= STOP_LVL;
`endif
                        end else begin
                            idx <= idx + IW'(1);
                            shift <= shift >> 1;
                            tx <= shift[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                        tx <= STOP_LVL;
                    end
`endif
                    STOP: begin
                        state <= IDLE;
                        tx <= IDLE_LVL;
                        tx_busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: per-cycle comparison of tx/tx_ready/tx_busy against a frame-queue model of the serial line.
module tb_uart_tx_engine;
    localparam int DB = 8;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tx, tx_busy;
    bit exp_q[$];
    bit m_arm;
    bit last_hs;
    int tests, fails;

    uart_tx_engine_if #(.DATA_BITS(DB), .DIV_W(16)) bus();
    uart_tx_engine #(.DIV_W(16), .DATA_BITS(DB)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .tx(tx),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    function automatic void push_frame(input logic [DB-1:0] d, input int div);
        int dv;
        bit bits[$];
        dv = (div == 0) ? 1 : div;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) for (int j = 0; j < dv; j++) exp_q.push_back(bits[i]);
    endfunction

    function automatic bit e_tx();
        return exp_q.size() != 0 ? exp_q[0] : 1'b1;
    endfunction
    function automatic bit e_rdy();
        return m_arm && exp_q.size() <= 1;
    endfunction
    function automatic bit e_busy();
        return exp_q.size() != 0;
    endfunction

    task automatic tick();
        logic [DB-1:0] d;
        int dv;
        bit rst;
        d = bus.tx_data;
        dv = int'(bus.clk_div);
        rst = !reset_n;
        last_hs = bus.tx_valid && e_rdy() && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_arm = 1'b0;
        end else begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (last_hs) push_frame(d, dv);
            m_arm = 1'b1;
        end
    endtask

    task automatic send(input logic [DB-1:0] d, input int div);
        bus.tx_data = d;
        bus.clk_div = 16'(div);
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'h5A;
        bus.clk_div = 16'd4;
        repeat (3) tick();
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b exp 1", tx); end
        tests++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", bus.tx_ready); end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
        bus.tx_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        tests++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b exp 1", bus.tx_ready); end
        tests++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin fails++; $display("FAIL reset_release_idle got tx=%b busy=%b exp tx=1 busy=0", tx, tx_busy); end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        bit t_tx;
        d = 8'hA5;
        send(d, 4);
        tests++; if (!last_hs) begin fails++; $display("FAIL basic_handshake got 0 exp 1"); end
        for (int k = 1; k <= 40; k++) begin
            t_tx = k <= 4 ? 1'b0 : k <= 36 ? d[(k-5)/4] : 1'b1;
            tests++; if (tx !== t_tx) begin fails++; $display("FAIL basic_tx cycle %0d got %b exp %b", k, tx, t_tx); end
            tests++; if (bus.tx_ready !== (k == 40)) begin fails++; $display("FAIL basic_ready cycle %0d got %b exp %b", k, bus.tx_ready, k == 40); end
            tests++; if (tx_busy !== 1'b1) begin fails++; $display("FAIL basic_busy cycle %0d got %b exp 1", k, tx_busy); end
            tests++; if (tx !== e_tx()) begin fails++; $display("FAIL basic_model_tx cycle %0d got %b exp %b", k, tx, e_tx()); end
            tick();
        end
        tests++; if (tx !== 1'b1 || bus.tx_ready !== 1'b1 || tx_busy !== 1'b0) begin fails++; $display("FAIL basic_idle got tx=%b rdy=%b busy=%b exp 1 1 0", tx, bus.tx_ready, tx_busy); end
    endtask

    task automatic test_back_to_back();
        int h[$];
        bus.tx_data = 8'h00;
        bus.clk_div = 16'd2;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (last_hs) begin
                h.push_back(i);
                bus.tx_data = 8'hFF;
                if (h.size() == 2) bus.tx_valid = 1'b0;
            end
            tests++; if (tx !== e_tx()) begin fails++; $display("FAIL b2b_tx cycle %0d got %b exp %b", i, tx, e_tx()); end
            tests++; if (bus.tx_ready !== e_rdy()) begin fails++; $display("FAIL b2b_ready cycle %0d got %b exp %b", i, bus.tx_ready, e_rdy()); end
            tests++; if (tx_busy !== e_busy()) begin fails++; $display("FAIL b2b_busy cycle %0d got %b exp %b", i, tx_busy, e_busy()); end
        end
        bus.tx_valid = 1'b0;
        tests++; if (h.size() != 2 || h[1] - h[0] != 20) begin fails++; $display("FAIL b2b_gap got %0d handshakes spacing %0d exp 2 spacing 20", h.size(), h.size() == 2 ? h[1] - h[0] : -1); end
    endtask

    task automatic test_div0();
        bit pat[10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
        send(8'h3C, 0);
        for (int k = 0; k < 10; k++) begin
            tests++; if (tx !== pat[k]) begin fails++; $display("FAIL div0_tx bit %0d got %b exp %b", k, tx, pat[k]); end
            tests++; if (bus.tx_ready !== (k == 9)) begin fails++; $display("FAIL div0_ready bit %0d got %b exp %b", k, bus.tx_ready, k == 9); end
            tick();
        end
        tests++; if (tx_busy !== 1'b0 || tx !== 1'b1) begin fails++; $display("FAIL div0_end got tx=%b busy=%b exp 1 0", tx, tx_busy); end
    endtask

    task automatic test_div_change();
        send(8'($urandom), 8);
        bus.clk_div = 16'd3;
        for (int i = 0; i < 85; i++) begin
            if (i == 82) bus.tx_valid = 1'b1;
            if (i == 83) bus.tx_valid = 1'b0;
            tests++; if (tx !== e_tx()) begin fails++; $display("FAIL divchg_tx cycle %0d got %b exp %b", i, tx, e_tx()); end
            tests++; if (bus.tx_ready !== e_rdy()) begin fails++; $display("FAIL divchg_ready cycle %0d got %b exp %b", i, bus.tx_ready, e_rdy()); end
            tick();
        end
        for (int i = 0; i < 30; i++) begin
            tests++; if (tx !== e_tx()) begin fails++; $display("FAIL divchg3_tx cycle %0d got %b exp %b", i, tx, e_tx()); end
            tests++; if (tx_busy !== e_busy()) begin fails++; $display("FAIL divchg3_busy cycle %0d got %b exp %b", i, tx_busy, e_busy()); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        send(8'($urandom), 3);
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        tests++; if (tx !== 1'b1 || bus.tx_ready !== 1'b0 || tx_busy !== 1'b0) begin fails++; $display("FAIL midreset got tx=%b rdy=%b busy=%b exp 1 0 0", tx, bus.tx_ready, tx_busy); end
        reset_n = 1'b1;
        tick();
        send(8'h55, 3);
        for (int i = 0; i < 32; i++) begin
            tests++; if (tx !== e_tx()) begin fails++; $display("FAIL midreset_tx cycle %0d got %b exp %b", i, tx, e_tx()); end
            tests++; if (bus.tx_ready !== e_rdy()) begin fails++; $display("FAIL midreset_ready cycle %0d got %b exp %b", i, bus.tx_ready, e_rdy()); end
            tick();
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] dat[2] = '{8'h07, 8'h03};
        bit pb[2] = '{1'b1, 1'b0};
        for (int n = 0; n < 2; n++) begin
            send(dat[n], 2);
            for (int k = 1; k <= 22; k++) begin
                if (k == 19 || k == 20) begin
                    tests++; if (tx !== pb[n]) begin fails++; $display("FAIL parity_bit data %h got %b exp %b", dat[n], tx, pb[n]); end
                end
                tests++; if (bus.tx_ready !== (k == 22)) begin fails++; $display("FAIL parity_ready cycle %0d got %b exp %b", k, bus.tx_ready, k == 22); end
                tests++; if (tx !== e_tx()) begin fails++; $display("FAIL parity_tx cycle %0d got %b exp %b", k, tx, e_tx()); end
                tick();
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.tx_valid = $urandom_range(0, 3) == 0;
            bus.tx_data = 8'($urandom);
            bus.clk_div = 16'($urandom_range(0, 5));
            reset_n = $urandom_range(0, 299) != 0;
            tick();
            tests++; if (tx !== e_tx()) begin fails++; $display("FAIL rand_tx cycle %0d got %b exp %b", i, tx, e_tx()); end
            tests++; if (bus.tx_ready !== e_rdy()) begin fails++; $display("FAIL rand_ready cycle %0d got %b exp %b", i, bus.tx_ready, e_rdy()); end
            tests++; if (tx_busy !== e_busy()) begin fails++; $display("FAIL rand_busy cycle %0d got %b exp %b", i, tx_busy, e_busy()); end
        end
        reset_n = 1'b1;
        bus.tx_valid = 1'b0;
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data = '0;
        bus.clk_div = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        repeat (3) tick();
        test_div0();
        test_div_change();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
